// File: rtl/lab3_pkg.sv
// Shared definitions for the Lab3 FSM datapath: fill-state encoding and default widths.
package lab3_pkg;

    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_EMPTY = 3'd0,
        ST_FILL1 = 3'd1,
        ST_FILL2 = 3'd2,
        ST_FILL3 = 3'd3,
        ST_ARMED = 3'd4
    } fill_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clr has priority over inc.
// Updates on the edge where inc is seen; no backpressure, it holds at all-ones.
module sat_counter
    import lab3_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         clock,
    input  logic         Reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/out1_pattern_detector.sv
// Matches the last four qualified samples of din against pattern; match pulses one cycle after the completing sample.
// All outputs registered; En gaps stall the window without losing history, there is no backpressure.
module out1_pattern_detector
    import lab3_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             Reset,
    input  logic             En,
    input  logic             din,
    input  logic             clear,
    input  logic             overlap,
    input  logic [PAT_W-1:0] pattern,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic [2:0]       fill_state
);

    fill_t            state;
    fill_t            state_nxt;
    fill_t            state_adv;
    logic [PAT_W-1:0] win;
    logic [PAT_W-1:0] win_nxt;
    logic             sample;
    logic             hit;

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state <= ST_EMPTY;
            win   <= '0;
            match <= 1'b0;
        end else begin
            state <= state_nxt;
            win   <= win_nxt;
            match <= hit;
        end
    end

    always_comb begin
        sample    = En && !clear;
        state_adv = (state == ST_ARMED) ? ST_ARMED : fill_t'(state + 3'd1);
        win_nxt   = win;
        state_nxt = state;
        hit       = 1'b0;

        if (clear) begin
            win_nxt   = '0;
            state_nxt = ST_EMPTY;
        end else if (sample) begin
            win_nxt   = {win[PAT_W-2:0], din};
            state_nxt = state_adv;
            // The hit is judged on the post-edge window, so the FILL3->ARMED edge can hit.
            hit = (state_adv == ST_ARMED) && (win_nxt == pattern);
            if (hit && !overlap) begin
                state_nxt = ST_EMPTY;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_hits (
        .clock (clock),
        .Reset (Reset),
        .inc   (hit),
        .clr   (clear),
        .count (match_count)
    );

    assign fill_state = state;

endmodule

// File: tb/tb_out1_pattern_detector.sv
// Directed vector table plus hand sequences for reset, saturation and the multi-cycle corners.
module tb_out1_pattern_detector;

    logic       clock = 1'b0;
    logic       Reset;
    logic       En;
    logic       din;
    logic       clear;
    logic       overlap;
    logic [3:0] pattern;
    logic       match;
    logic [7:0] match_count;
    logic [2:0] fill_state;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       en;
        logic       din;
        logic       clr;
        logic       ovl;
        logic [3:0] pat;
        logic       m;
        logic [7:0] cnt;
        logic [2:0] fs;
    } vec_t;

    vec_t vecs[$];

    always #5 clock = ~clock;

    out1_pattern_detector #(.PAT_W(4), .CNT_W(8)) dut (
        .clock       (clock),
        .Reset       (Reset),
        .En          (En),
        .din         (din),
        .clear       (clear),
        .overlap     (overlap),
        .pattern     (pattern),
        .match       (match),
        .match_count (match_count),
        .fill_state  (fill_state)
    );

    task automatic add(input logic en, input logic d, input logic clr, input logic ovl,
                       input logic [3:0] pat, input logic m, input logic [7:0] cnt,
                       input logic [2:0] fs);
        vec_t v;
        v.en = en; v.din = d; v.clr = clr; v.ovl = ovl; v.pat = pat;
        v.m = m; v.cnt = cnt; v.fs = fs;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic m, input logic [7:0] cnt, input logic [2:0] fs);
        n_checks++;
        if (match !== m || match_count !== cnt || fill_state !== fs) begin
            n_fail++;
            $display("FAIL %s: got match=%b count=%0d fill=%0d, expected match=%b count=%0d fill=%0d",
                     name, match, match_count, fill_state, m, cnt, fs);
        end
    endtask

    task automatic step(input logic en, input logic d, input logic clr);
        @(negedge clock);
        En = en; din = d; clear = clr;
        @(posedge clock);
        #1;
    endtask

    initial begin
        Reset = 1'b0; En = 1'b0; din = 1'b0; clear = 1'b0; overlap = 1'b0; pattern = 4'b0000;
        #1;
        chk("reset_state", 1'b0, 8'd0, 3'd0);
        @(negedge clock);
        Reset = 1'b1;

        // overlap=1, pattern 1010, stream 101010: hits after samples 4 and 6
        add(1,1,0,1,4'b1010, 0,0,1);
        add(1,0,0,1,4'b1010, 0,0,2);
        add(1,1,0,1,4'b1010, 0,0,3);
        add(1,0,0,1,4'b1010, 1,1,4);
        add(1,1,0,1,4'b1010, 0,1,4);
        add(1,0,0,1,4'b1010, 1,2,4);
        add(0,0,1,1,4'b1010, 0,0,0);
        // overlap=0, same stream: only one hit, window restarts
        add(1,1,0,0,4'b1010, 0,0,1);
        add(1,0,0,0,4'b1010, 0,0,2);
        add(1,1,0,0,4'b1010, 0,0,3);
        add(1,0,0,0,4'b1010, 1,1,0);
        add(1,1,0,0,4'b1010, 0,1,1);
        add(1,0,0,0,4'b1010, 0,1,2);
        add(0,0,1,0,4'b1010, 0,0,0);
        // En gaps: pattern 1100, three idle cycles between samples
        add(1,1,0,0,4'b1100, 0,0,1);
        for (int g = 0; g < 3; g++) add(0,0,0,0,4'b1100, 0,0,1);
        add(1,1,0,0,4'b1100, 0,0,2);
        for (int g = 0; g < 3; g++) add(0,1,0,0,4'b1100, 0,0,2);
        add(1,0,0,0,4'b1100, 0,0,3);
        for (int g = 0; g < 3; g++) add(0,1,0,0,4'b1100, 0,0,3);
        add(1,0,0,0,4'b1100, 1,1,0);
        add(0,0,0,0,4'b1100, 0,1,0);
        add(0,0,1,0,4'b1100, 0,0,0);
        // clear collides with a sample while in FILL3; pattern 1011 would hit if the sample were taken
        add(1,1,0,0,4'b1011, 0,0,1);
        add(1,0,0,0,4'b1011, 0,0,2);
        add(1,1,0,0,4'b1011, 0,0,3);
        add(1,1,1,0,4'b1011, 0,0,0);
        add(1,1,0,0,4'b1011, 0,0,1);
        add(0,0,1,0,4'b1011, 0,0,0);
        // pattern change while ARMED on 0110: 1111 -> 1101 right before a sample of 1
        add(1,0,0,1,4'b1111, 0,0,1);
        add(1,1,0,1,4'b1111, 0,0,2);
        add(1,1,0,1,4'b1111, 0,0,3);
        add(1,0,0,1,4'b1111, 0,0,4);
        add(1,1,0,1,4'b1101, 1,1,4);
        add(0,0,1,1,4'b1101, 0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            overlap = vecs[i].ovl;
            pattern = vecs[i].pat;
            En      = vecs[i].en;
            din     = vecs[i].din;
            clear   = vecs[i].clr;
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d", i), vecs[i].m, vecs[i].cnt, vecs[i].fs);
        end

        // Async reset mid-stream with match_count=5 and match high
        overlap = 1'b1; pattern = 4'b1111;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
        chk("pre_reset_count5", 1'b1, 8'd5, 3'd4);
        #2;
        Reset = 1'b0;
        #1;
        chk("async_reset_immediate", 1'b0, 8'd0, 3'd0);
        @(negedge clock);
        Reset = 1'b1;
        En = 1'b0;
        overlap = 1'b0; pattern = 4'b1011;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("post_reset_fill3", 1'b0, 8'd0, 3'd3);
        step(1'b1, 1'b1, 1'b0);
        chk("post_reset_hit", 1'b1, 8'd1, 3'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("post_reset_pulse_end", 1'b0, 8'd1, 3'd0);

        // Saturation: 300 samples of 1 against 1111 in overlap mode
        step(1'b0, 1'b0, 1'b1);
        overlap = 1'b1; pattern = 4'b1111;
        for (int i = 0; i < 300; i++) begin
            logic       em;
            logic [7:0] ec;
            logic [2:0] ef;
            step(1'b1, 1'b1, 1'b0);
            em = (i >= 3);
            ec = (i < 3) ? 8'd0 : ((i - 2) > 255 ? 8'd255 : 8'((i - 2)));
            ef = (i < 3) ? 3'(i + 1) : 3'd4;
            chk($sformatf("sat%0d", i), em, ec, ef);
        end
        step(1'b0, 1'b1, 1'b0);
        chk("sat_hold", 1'b0, 8'd255, 3'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
